// File: rtl/alu_acc_unit.sv
// alu_acc_unit: 8-bit accumulator execute stage fed by the register file read
// ports and an instruction immediate. Ops start with a start/busy/done handshake;
// STA drives a single-cycle register-file write pulse.
// Optional feature macro ALU_MUL_EN: when defined, opcode 110 is a multi-cycle
// shift-add multiply; when undefined, opcode 110 is a one-cycle NOP.
module alu_acc_unit #(
    parameter int word_size  = 8,
    parameter int index_size = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            opcode,
    input  logic [word_size-1:0]  operand_a,
    input  logic [word_size-1:0]  operand_b,
    input  logic [word_size-1:0]  imm,
    input  logic [index_size-1:0] dest_addr,
    output logic                  busy,
    output logic                  done,
    output logic [word_size-1:0]  acc,
    output logic                  zero_flag,
    output logic                  carry_flag,
    output logic                  write_enable,
    output logic [index_size-1:0] write_address,
    output logic [word_size-1:0]  write_data
);

    typedef enum logic [2:0] {
        OP_LDA = 3'b000,
        OP_LDI = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_MUL = 3'b110,
        OP_STA = 3'b111
    } opcode_t;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } state_t;

    localparam logic [3:0] MUL_STEPS = 4'd8;

    logic [3:0]             mul_count;
    logic [2*word_size-1:0] mul_product;
    logic [2*word_size-1:0] mul_mcand;
    logic [word_size-1:0]   mul_mplier;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1
    } state_t;

    // operand_b only feeds the multiplier, which is absent in this build
    logic unused_operand_b;
    assign unused_operand_b = ^operand_b;
`endif

    state_t                state, state_next;
    opcode_t               op_q;
    logic [word_size-1:0]  a_q;
    logic [word_size-1:0]  imm_q;
    logic [index_size-1:0] dest_q;
    logic                  accept;
    logic [word_size:0]    sum_ext;
    logic [word_size:0]    diff_ext;

    assign accept = (state == ST_IDLE) && start;
    assign busy   = (state != ST_IDLE);

    // Carry-out of the add and borrow of the subtract both land in the extra top bit
    always_comb begin
        sum_ext  = {1'b0, acc} + {1'b0, a_q};
        diff_ext = {1'b0, acc} - {1'b0, a_q};
    end

    // State register
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
`ifdef ALU_MUL_EN
                    state_next = (opcode_t'(opcode) == OP_MUL) ? ST_MUL : ST_EXEC;
`else
                    state_next = ST_EXEC;
`endif
                end
            end
            ST_EXEC: state_next = ST_IDLE;
`ifdef ALU_MUL_EN
            ST_MUL:  if (mul_count == MUL_STEPS) state_next = ST_IDLE;
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand capture on accept, accumulator/flag update, done and write pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q          <= OP_LDA;
            a_q           <= '0;
            imm_q         <= '0;
            dest_q        <= '0;
            acc           <= '0;
            zero_flag     <= 1'b0;
            carry_flag    <= 1'b0;
            done          <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
`ifdef ALU_MUL_EN
            mul_count     <= '0;
            mul_product   <= '0;
            mul_mcand     <= '0;
            mul_mplier    <= '0;
`endif
        end else begin
            done         <= 1'b0;
            write_enable <= 1'b0;

            if (accept) begin
                op_q   <= opcode_t'(opcode);
                a_q    <= operand_a;
                imm_q  <= imm;
                dest_q <= dest_addr;
`ifdef ALU_MUL_EN
                mul_count   <= '0;
                mul_product <= '0;
                mul_mcand   <= {{word_size{1'b0}}, operand_a};
                mul_mplier  <= operand_b;
`endif
            end

            if (state == ST_EXEC) begin
                done <= 1'b1;
                case (op_q)
                    OP_LDA: begin
                        acc        <= a_q;
                        zero_flag  <= (a_q == '0);
                        carry_flag <= 1'b0;
                    end
                    OP_LDI: begin
                        acc        <= imm_q;
                        zero_flag  <= (imm_q == '0);
                        carry_flag <= 1'b0;
                    end
                    OP_ADD: begin
                        acc        <= sum_ext[word_size-1:0];
                        zero_flag  <= (sum_ext[word_size-1:0] == '0);
                        carry_flag <= sum_ext[word_size];
                    end
                    OP_SUB: begin
                        acc        <= diff_ext[word_size-1:0];
                        zero_flag  <= (diff_ext[word_size-1:0] == '0);
                        carry_flag <= diff_ext[word_size];
                    end
                    OP_AND: begin
                        acc        <= acc & a_q;
                        zero_flag  <= ((acc & a_q) == '0);
                        carry_flag <= 1'b0;
                    end
                    OP_OR: begin
                        acc        <= acc | a_q;
                        zero_flag  <= ((acc | a_q) == '0);
                        carry_flag <= 1'b0;
                    end
                    OP_STA: begin
                        write_enable  <= 1'b1;
                        write_address <= dest_q;
                        write_data    <= acc;
                    end
                    default: ; // OP_MUL reaches here only as the NOP build
                endcase
            end

`ifdef ALU_MUL_EN
            if (state == ST_MUL) begin
                if (mul_count == MUL_STEPS) begin
                    acc        <= mul_product[word_size-1:0];
                    zero_flag  <= (mul_product[word_size-1:0] == '0);
                    carry_flag <= |mul_product[2*word_size-1:word_size];
                    done       <= 1'b1;
                end else begin
                    if (mul_mplier[0]) mul_product <= mul_product + mul_mcand;
                    mul_mcand  <= mul_mcand << 1;
                    mul_mplier <= mul_mplier >> 1;
                    mul_count  <= mul_count + 4'd1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_acc_unit.sv
// tb_alu_acc_unit: scoreboard bench for alu_acc_unit. A driver issues ops and
// pushes the reference model's expected response; a monitor pops and compares
// whenever done is presented. Honours ALU_MUL_EN the same way as the design.
module tb_alu_acc_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] opcode = '0;
    logic [7:0] operand_a = '0, operand_b = '0, imm = '0;
    logic [3:0] dest_addr = '0;
    logic       busy, done, zero_flag, carry_flag, write_enable;
    logic [7:0] acc, write_data;
    logic [3:0] write_address;

    alu_acc_unit #(.word_size(8), .index_size(4)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b), .imm(imm),
        .dest_addr(dest_addr), .busy(busy), .done(done), .acc(acc),
        .zero_flag(zero_flag), .carry_flag(carry_flag),
        .write_enable(write_enable), .write_address(write_address),
        .write_data(write_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] acc;
        logic       zero;
        logic       carry;
        logic       we;
        logic [3:0] waddr;
        logic [7:0] wdata;
        int         accept_cyc;
        int         latency;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model state
    logic [7:0] m_acc   = '0;
    logic       m_zero  = 1'b0;
    logic       m_carry = 1'b0;

    // Register file modelled downstream of the write port
    logic [7:0] tb_regs [16];
    logic       pend_valid = 1'b0;
    logic [3:0] pend_addr;
    logic [7:0] pend_data;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (write_enable) tb_regs[write_address] <= write_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_acc"},   acc, 0);
        check({tag, "_zero"},  zero_flag, 0);
        check({tag, "_carry"}, carry_flag, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_we"},    write_enable, 0);
        check({tag, "_waddr"}, write_address, 0);
        check({tag, "_wdata"}, write_data, 0);
    endtask

    // Architectural effect of one op, from the opcode table
    function automatic exp_t model_step(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] im,
                                        input logic [3:0] dest);
        exp_t e;
        int   r;
        e.we = 1'b0; e.waddr = '0; e.wdata = '0; e.latency = 1; e.accept_cyc = 0;
        case (op)
            3'd0: begin m_acc = a;  m_carry = 1'b0; m_zero = (m_acc == 0); end
            3'd1: begin m_acc = im; m_carry = 1'b0; m_zero = (m_acc == 0); end
            3'd2: begin
                r = int'(m_acc) + int'(a);
                m_carry = (r > 255); m_acc = 8'(r % 256); m_zero = (m_acc == 0);
            end
            3'd3: begin
                m_carry = (m_acc < a);
                r = int'(m_acc) - int'(a);
                if (r < 0) r += 256;
                m_acc = 8'(r); m_zero = (m_acc == 0);
            end
            3'd4: begin m_acc = m_acc & a; m_carry = 1'b0; m_zero = (m_acc == 0); end
            3'd5: begin m_acc = m_acc | a; m_carry = 1'b0; m_zero = (m_acc == 0); end
            3'd6: begin
`ifdef ALU_MUL_EN
                r = int'(a) * int'(b);
                m_acc = 8'(r % 256); m_carry = ((r / 256) != 0); m_zero = (m_acc == 0);
                e.latency = 9;
`endif
            end
            default: begin e.we = 1'b1; e.waddr = dest; e.wdata = m_acc; end
        endcase
        e.acc = m_acc; e.zero = m_zero; e.carry = m_carry;
        return e;
    endfunction

    // Issue one op once the unit is idle; while busy, stray start pulses must be ignored
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] im, input logic [3:0] dest, input bit keep);
        int   waited = 0;
        exp_t e;
        @(negedge clk);
        while (busy) begin
            start     = 1'($urandom_range(0, 1));
            opcode    = 3'($urandom);
            operand_a = 8'($urandom);
            operand_b = 8'($urandom);
            imm       = 8'($urandom);
            dest_addr = 4'($urandom);
            waited++;
            if (waited > 40) begin
                check("busy_timeout", busy, 0);
                break;
            end
            @(negedge clk);
        end
        start = 1'b1; opcode = op; operand_a = a; operand_b = b; imm = im; dest_addr = dest;
        @(posedge clk);
        #1;
        start     = 1'b0;
        opcode    = 3'($urandom);
        operand_a = 8'($urandom);
        operand_b = 8'($urandom);
        imm       = 8'($urandom);
        dest_addr = 4'($urandom);
        check("busy_after_accept", busy, 1);
        if (keep) begin
            e = model_step(op, a, b, im, dest);
            e.accept_cyc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
        @(negedge clk);
    endtask

    // Monitor: compare every presented completion against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (pend_valid) begin
                check("regfile_commit", tb_regs[pend_addr], pend_data);
                pend_valid = 1'b0;
            end
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    e = q.pop_front();
                    check("latency", cyc - e.accept_cyc, e.latency);
                    check("acc", acc, e.acc);
                    check("zero_flag", zero_flag, e.zero);
                    check("carry_flag", carry_flag, e.carry);
                    check("busy_in_done", busy, 0);
                    check("write_enable", write_enable, e.we);
                    if (e.we) begin
                        check("write_address", write_address, e.waddr);
                        check("write_data", write_data, e.wdata);
                        pend_valid = 1'b1;
                        pend_addr  = e.waddr;
                        pend_data  = e.wdata;
                    end
                end
            end else begin
                check("we_without_done", write_enable, 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        @(negedge clk);
        check_reset("idle");

        // Directed sequence from the opcode table
        issue(3'd1, 8'h00, 8'h00, 8'hF0, 4'd0, 1'b1);   // LDI 0xF0
        issue(3'd2, 8'h20, 8'h00, 8'h00, 4'd0, 1'b1);   // ADD 0x20
        drain();
        check("plan_add_acc", acc, 8'h10);
        check("plan_add_carry", carry_flag, 1);
        issue(3'd1, 8'h00, 8'h00, 8'h05, 4'd0, 1'b1);   // LDI 0x05
        issue(3'd3, 8'h05, 8'h00, 8'h00, 4'd0, 1'b1);   // SUB 0x05
        drain();
        check("plan_sub_zero", zero_flag, 1);
        issue(3'd3, 8'h01, 8'h00, 8'h00, 4'd0, 1'b1);   // SUB 0x01
        drain();
        check("plan_sub_wrap", acc, 8'hFF);
        issue(3'd6, 8'h12, 8'h10, 8'h00, 4'd0, 1'b1);   // MUL or NOP
        drain();
`ifdef ALU_MUL_EN
        check("plan_mul_acc", acc, 8'h20);
`else
        check("plan_nop_acc", acc, 8'hFF);
`endif
        issue(3'd1, 8'h00, 8'h00, 8'h2A, 4'd0, 1'b1);   // LDI 0x2A
        issue(3'd7, 8'h00, 8'h00, 8'h00, 4'd7, 1'b1);   // STA r7
        drain();
        check("plan_r7", tb_regs[7], 8'h2A);

        // Reset while an op is in flight: no completion, no write
        issue(3'd6, 8'hFF, 8'hFF, 8'h00, 4'd3, 1'b0);
        #2;
        rst = 1'b1;
        m_acc = '0; m_zero = 1'b0; m_carry = 1'b0;
        @(negedge clk);
        check_reset("abort");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("no_done_after_abort", done, 0);
        end
        check_reset("post_abort");

        // Randomized traffic, small operands sometimes to hit zero results
        for (int i = 0; i < 250; i++) begin
            logic [7:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom);
            b = 8'($urandom);
            issue(3'($urandom), a, b, 8'($urandom_range(0, 1) ? $urandom : 0),
                  4'($urandom), 1'b1);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
